// File: rtl/high_page_responder.sv
// rtl/high_page_responder.sv - high-page (0xFF00-0xFFFF) bus responder: HRAM, IE and IO forwarding
//
// Ports:
//   i_Clk, i_Reset_n       clock, asynchronous active-low reset
//   i_Addr/i_Read/i_Write  CPU access; accepted only in IDLE when o_Hit=1
//   i_Data                 CPU write data
//   o_Data/o_Ack           read data and one-cycle completion strobe
//   o_Busy                 access in flight, new requests ignored
//   o_Hit                  combinational high-page decode
//   o_IO_*/i_IO_*          peripheral req/ack handshake for 0xFF00-0xFF7F
//   o_IE                   interrupt-enable register
module high_page_responder #(
  parameter int          IO_TIMEOUT     = 8,
  parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic [15:0] i_Addr,
  input  logic        i_Read,
  input  logic        i_Write,
  input  logic [7:0]  i_Data,
  output logic [7:0]  o_Data,
  output logic        o_Ack,
  output logic        o_Busy,
  output logic        o_Hit,
  output logic        o_IO_Req,
  output logic        o_IO_Write,
  output logic [6:0]  o_IO_Addr,
  output logic [7:0]  o_IO_Wdata,
  input  logic        i_IO_Ack,
  input  logic [7:0]  i_IO_Rdata,
  output logic [7:0]  o_IE
);

  typedef enum logic [1:0] {S_IDLE, S_LOCAL, S_IO_WAIT} state_t;

  // Timeout fires at the end of the IO_TIMEOUT-th IO_WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(IO_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_data;
  logic        r_ack;
  logic        r_io_req;
  logic        r_io_write;
  logic [6:0]  r_io_addr;
  logic [7:0]  r_io_wdata;
  logic [7:0]  r_ie;
  logic [7:0]  r_count;
  logic [7:0]  r_hram [0:126];

  logic        w_accept;
  logic        w_local;
  logic        w_timeout;
  logic [7:0]  w_local_rdata;

  assign o_Hit      = (i_Addr[15:8] == 8'hFF) && (i_Read || i_Write);
  assign w_accept   = (r_state == S_IDLE) && o_Hit;
  assign w_local    = i_Addr[7];
  assign w_timeout  = (r_count == TIMEOUT_LAST);

  // Offset 0x7F is IE, never HRAM.
  assign w_local_rdata = (i_Addr[6:0] == 7'h7F) ? r_ie : r_hram[i_Addr[6:0]];

  assign o_Data     = r_data;
  assign o_Ack      = r_ack;
  assign o_Busy     = (r_state != S_IDLE);
  assign o_IO_Req   = r_io_req;
  assign o_IO_Write = r_io_write;
  assign o_IO_Addr  = r_io_addr;
  assign o_IO_Wdata = r_io_wdata;
  assign o_IE       = r_ie;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_local ? S_LOCAL : S_IO_WAIT;
      S_LOCAL:   w_next = S_IDLE;
      S_IO_WAIT: if (i_IO_Ack || w_timeout) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Local reads return data and ack straight from the accept edge so the
  // strobe lands one cycle after the request; local writes commit at the
  // end of the LOCAL cycle.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_data     <= 8'h00;
      r_ack      <= 1'b0;
      r_io_req   <= 1'b0;
      r_io_write <= 1'b0;
      r_io_addr  <= 7'h00;
      r_io_wdata <= 8'h00;
      r_ie       <= 8'h00;
      r_count    <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Read+write together is a write; the read is dropped.
            r_io_write <= i_Write;
            r_io_addr  <= i_Addr[6:0];
            r_io_wdata <= i_Data;
            r_count    <= 8'h00;
            if (w_local) begin
              r_ack <= 1'b1;
              if (!i_Write) r_data <= w_local_rdata;
            end else begin
              r_io_req <= 1'b1;
            end
          end
        end
        S_LOCAL: begin
          if (r_io_write && (r_io_addr == 7'h7F)) r_ie <= r_io_wdata;
        end
        S_IO_WAIT: begin
          r_count <= r_count + 8'd1;
          if (i_IO_Ack) begin
            r_io_req <= 1'b0;
            r_ack    <= 1'b1;
            if (!r_io_write) r_data <= i_IO_Rdata;
          end else if (w_timeout) begin
            r_io_req <= 1'b0;
            r_ack    <= 1'b1;
            if (!r_io_write) r_data <= OPEN_BUS_VALUE;
          end
        end
        default: ;
      endcase
    end
  end

  // HRAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge i_Clk) begin
    if ((r_state == S_LOCAL) && r_io_write && (r_io_addr != 7'h7F))
      r_hram[r_io_addr] <= r_io_wdata;
  end

endmodule

// File: tb/tb_high_page_responder.sv
// tb/tb_high_page_responder.sv - self-checking bench for high_page_responder
module tb_high_page_responder;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rd = 1'b0, wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        io_ack = 1'b0;
  logic [7:0]  io_rdata = 8'h00;
  logic [7:0]  o_Data, o_IO_Wdata, o_IE;
  logic        o_Ack, o_Busy, o_Hit, o_IO_Req, o_IO_Write;
  logic [6:0]  o_IO_Addr;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model of the architecturally visible state.
  logic [7:0] m_hram [0:126];
  logic [7:0] m_ie = 8'h00;
  logic [7:0] m_data = 8'h00;

  always #5 clk = ~clk;

  high_page_responder #(.IO_TIMEOUT(TMO), .OPEN_BUS_VALUE(8'hFF)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Addr(addr), .i_Read(rd), .i_Write(wr),
    .i_Data(wdata), .o_Data(o_Data), .o_Ack(o_Ack), .o_Busy(o_Busy), .o_Hit(o_Hit),
    .o_IO_Req(o_IO_Req), .o_IO_Write(o_IO_Write), .o_IO_Addr(o_IO_Addr),
    .o_IO_Wdata(o_IO_Wdata), .i_IO_Ack(io_ack), .i_IO_Rdata(io_rdata), .o_IE(o_IE)
  );

  // One bus access; the peripheral acks on its ack_at-th request cycle
  // (0 = never). Returns latency in cycles and observed handshake.
  task automatic access(input logic [15:0] a, input bit do_rd, input bit do_wr,
                        input logic [7:0] d, input int ack_at, input logic [7:0] rdat,
                        output int lat, output int reqc, output bit acked,
                        output logic [7:0] dout, output bit io_ok);
    lat = 0; reqc = 0; acked = 0; dout = 8'h00; io_ok = 1;
    @(negedge clk);
    addr = a; rd = do_rd; wr = do_wr; wdata = d;
    for (int c = 1; c <= 40 && !acked; c++) begin
      @(negedge clk);
      rd = 0; wr = 0; io_ack = 0;
      if (o_Ack) begin
        acked = 1; lat = c; dout = o_Data;
      end else if (o_IO_Req) begin
        reqc++;
        if (o_IO_Addr !== a[6:0] || o_IO_Write !== do_wr || (do_wr && o_IO_Wdata !== d))
          io_ok = 0;
        if (reqc == ack_at) begin io_ack = 1; io_rdata = rdat; end
      end
    end
    io_ack = 0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (o_IE !== 8'h00 || o_Ack !== 1'b0 || o_IO_Req !== 1'b0 || o_Busy !== 1'b0 || o_Data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: ie=%h ack=%b req=%b busy=%b data=%h, want 00/0/0/0/00",
               o_IE, o_Ack, o_IO_Req, o_Busy, o_Data);
    end
  endtask

  task automatic test_ie;
    int lat, reqc; bit acked, ok; logic [7:0] d;
    access(16'hFFFF, 0, 1, 8'h1F, 0, 8'h00, lat, reqc, acked, d, ok);
    m_ie = 8'h1F;
    n_checks++;
    if (!acked || lat != 1) begin n_fail++; $display("FAIL ie_write_ack: acked=%0d lat=%0d, want 1/1", acked, lat); end
    @(negedge clk);
    n_checks++;
    if (o_IE !== m_ie) begin n_fail++; $display("FAIL ie_value: got %h want %h", o_IE, m_ie); end
    access(16'hFFFF, 1, 0, 8'h00, 0, 8'h00, lat, reqc, acked, d, ok);
    m_data = m_ie;
    n_checks++;
    if (!acked || lat != 1 || d !== m_ie) begin
      n_fail++; $display("FAIL ie_read: acked=%0d lat=%0d data=%h, want 1/1/%h", acked, lat, d, m_ie);
    end
  endtask

  task automatic test_hram;
    int lat, reqc; bit acked, ok; logic [7:0] d;
    access(16'hFF80, 0, 1, 8'hA5, 0, 8'h00, lat, reqc, acked, d, ok); m_hram[0] = 8'hA5;
    access(16'hFFFE, 0, 1, 8'h5A, 0, 8'h00, lat, reqc, acked, d, ok); m_hram[126] = 8'h5A;
    access(16'hFF80, 1, 0, 8'h00, 0, 8'h00, lat, reqc, acked, d, ok); m_data = m_hram[0];
    n_checks++;
    if (!acked || lat != 1 || d !== 8'hA5) begin n_fail++; $display("FAIL hram_ff80: acked=%0d lat=%0d data=%h, want 1/1/a5", acked, lat, d); end
    access(16'hFFFE, 1, 0, 8'h00, 0, 8'h00, lat, reqc, acked, d, ok); m_data = m_hram[126];
    n_checks++;
    if (!acked || lat != 1 || d !== 8'h5A) begin n_fail++; $display("FAIL hram_fffe: acked=%0d lat=%0d data=%h, want 1/1/5a", acked, lat, d); end
  endtask

  task automatic test_miss;
    int acks = 0;
    @(negedge clk);
    addr = 16'hFF80; rd = 1; #1;
    n_checks++;
    if (o_Hit !== 1'b1) begin n_fail++; $display("FAIL hit_ff80: got %b want 1", o_Hit); end
    addr = 16'hFE80; #1;
    n_checks++;
    if (o_Hit !== 1'b0) begin n_fail++; $display("FAIL hit_fe80: got %b want 0", o_Hit); end
    io_ack = 1;  // stray peripheral ack while idle must be ignored
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (o_Ack) acks++; end
    rd = 0; io_ack = 0;
    n_checks++;
    if (acks != 0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL miss_no_ack: acks=%0d busy=%b want 0/0", acks, o_Busy); end
  endtask

  task automatic test_io_read;
    int lat, reqc; bit acked, ok; logic [7:0] d;
    access(16'hFF44, 1, 0, 8'h00, 3, 8'h90, lat, reqc, acked, d, ok);
    m_data = 8'h90;
    n_checks++;
    if (!acked || reqc != 3 || lat != 4 || d !== 8'h90 || !ok) begin
      n_fail++; $display("FAIL io_read: acked=%0d req=%0d lat=%0d data=%h io_ok=%0d, want 1/3/4/90/1", acked, reqc, lat, d, ok);
    end
  endtask

  task automatic test_io_timeout;
    int lat, reqc; bit acked, ok; logic [7:0] d;
    access(16'hFF10, 1, 0, 8'h00, 0, 8'h00, lat, reqc, acked, d, ok);
    m_data = 8'hFF;
    n_checks++;
    if (!acked || reqc != TMO || d !== 8'hFF) begin
      n_fail++; $display("FAIL io_timeout: acked=%0d req=%0d data=%h, want 1/%0d/ff", acked, reqc, d, TMO);
    end
    access(16'hFF10, 1, 0, 8'h00, TMO, 8'h33, lat, reqc, acked, d, ok);
    m_data = 8'h33;
    n_checks++;
    if (!acked || reqc != TMO || d !== 8'h33) begin
      n_fail++; $display("FAIL io_ack_at_timeout: acked=%0d req=%0d data=%h, want 1/%0d/33", acked, reqc, d, TMO);
    end
  endtask

  task automatic test_reset_mid_io;
    int lat, reqc; bit acked, ok; logic [7:0] d;
    int acks = 0;
    @(negedge clk);
    addr = 16'hFF20; rd = 1;
    @(negedge clk); rd = 0;
    @(negedge clk);
    n_checks++;
    if (o_IO_Req !== 1'b1) begin n_fail++; $display("FAIL mid_io_req: got %b want 1", o_IO_Req); end
    #2 rst_n = 0; #1;
    m_ie = 8'h00; m_data = 8'h00;
    n_checks++;
    if (o_IO_Req !== 1'b0 || o_Busy !== 1'b0 || o_Ack !== 1'b0 || o_IE !== 8'h00) begin
      n_fail++; $display("FAIL mid_io_reset: req=%b busy=%b ack=%b ie=%h, want 0/0/0/00", o_IO_Req, o_Busy, o_Ack, o_IE);
    end
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (o_Ack) acks++; end
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (o_Ack) acks++; end
    n_checks++;
    if (acks != 0) begin n_fail++; $display("FAIL mid_io_no_ack: acks=%0d want 0", acks); end
    access(16'hFF80, 1, 0, 8'h00, 0, 8'h00, lat, reqc, acked, d, ok);
    m_data = m_hram[0];
    n_checks++;
    if (!acked || d !== m_hram[0]) begin n_fail++; $display("FAIL hram_after_reset: acked=%0d data=%h want 1/%h", acked, d, m_hram[0]); end
  endtask

  task automatic test_rw_busy;
    int lat, reqc; bit acked, ok; logic [7:0] d;
    int acks = 0;
    @(negedge clk);
    addr = 16'hFF90; rd = 1; wr = 1; wdata = 8'h77;
    @(negedge clk);
    m_hram[16] = 8'h77;
    n_checks++;
    if (o_Ack !== 1'b1 || o_Busy !== 1'b1 || o_Data !== m_data) begin
      n_fail++; $display("FAIL rw_ack: ack=%b busy=%b data=%h, want 1/1/%h", o_Ack, o_Busy, o_Data, m_data);
    end
    // New request while busy: must be ignored.
    addr = 16'hFF90; rd = 0; wr = 1; wdata = 8'h11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rd = 0; wr = 0;
      if (o_Ack) acks++;
    end
    n_checks++;
    if (acks != 0) begin n_fail++; $display("FAIL busy_ignored: acks=%0d want 0", acks); end
    access(16'hFF90, 1, 0, 8'h00, 0, 8'h00, lat, reqc, acked, d, ok);
    m_data = m_hram[16];
    n_checks++;
    if (!acked || d !== 8'h77) begin n_fail++; $display("FAIL rw_readback: acked=%0d data=%h want 1/77", acked, d); end
  endtask

  task automatic test_random;
    int lat, reqc; bit acked, ok; logic [7:0] d, v, exp_d;
    int idx, ack_at, exp_req;
    bit is_wr;
    for (int i = 0; i < 127; i++) begin
      v = 8'($urandom);
      access(16'hFF80 + 16'(i), 0, 1, v, 0, 8'h00, lat, reqc, acked, d, ok);
      m_hram[i] = v;
      n_checks++;
      if (!acked || lat != 1) begin n_fail++; $display("FAIL fill_%0d: acked=%0d lat=%0d want 1/1", i, acked, lat); end
    end
    for (int i = 0; i < 120; i++) begin
      is_wr = 1'($urandom);
      v = 8'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, 127);
        access(16'hFF80 + 16'(idx), !is_wr, is_wr, v, 0, 8'h00, lat, reqc, acked, d, ok);
        if (is_wr) begin
          if (idx == 127) m_ie = v; else m_hram[idx] = v;
        end else begin
          m_data = (idx == 127) ? m_ie : m_hram[idx];
        end
        n_checks++;
        if (!acked || lat != 1 || reqc != 0 || d !== m_data) begin
          n_fail++; $display("FAIL rand_local_%0d: idx=%0d wr=%0d acked=%0d lat=%0d data=%h want 1/1/%h", i, idx, is_wr, acked, lat, d, m_data);
        end
      end else begin
        idx = $urandom_range(0, 127);
        ack_at = $urandom_range(0, TMO + 2);
        access(16'hFF00 + 16'(idx), !is_wr, is_wr, v, ack_at, 8'($urandom + i), lat, reqc, acked, d, ok);
        exp_req = (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO;
        exp_d = (ack_at >= 1 && ack_at <= TMO) ? 8'($urandom + i) : 8'hFF;
        if (!is_wr) m_data = (ack_at >= 1 && ack_at <= TMO) ? io_rdata : 8'hFF;
        n_checks++;
        if (!acked || reqc != exp_req || lat != exp_req + 1 || d !== m_data || !ok) begin
          n_fail++; $display("FAIL rand_io_%0d: wr=%0d ack_at=%0d acked=%0d req=%0d lat=%0d data=%h io_ok=%0d want req=%0d data=%h",
                             i, is_wr, ack_at, acked, reqc, lat, d, ok, exp_req, m_data);
        end
        if (exp_d == 8'h00) ; // exp_d unused beyond stimulus symmetry
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_IE !== m_ie) begin n_fail++; $display("FAIL rand_ie: got %h want %h", o_IE, m_ie); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_reset;
    test_ie;
    test_hram;
    test_miss;
    test_io_read;
    test_io_timeout;
    test_reset_mid_io;
    test_rw_busy;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/high_page_responder.md
Name: high_page_responder

Overview:
- Bus-side responder for the 0xFF00–0xFFFF high page, which the LDH (a8)/(C) loads and stores target.
- Decodes each CPU access to that page and serves it from one of three targets:
  - HRAM at 0xFF80–0xFFFE, a 127-byte internal register file.
  - IE register at 0xFFFF.
  - Peripheral IO at 0xFF00–0xFF7F, forwarded over a req/ack handshake with timeout.
- Sits between the CPU data/address bus and the IO peripherals. Returns read data and a completion strobe that the control unit uses to advance the cycle step.

Parameters:
- IO_TIMEOUT, 8, number of cycles to wait for i_IO_Ack before abandoning an IO access (range 1–255).
- OPEN_BUS_VALUE, 8'hFF, read data returned on an IO timeout.

Ports:
- i_Clk  input  1  system clock; all state changes on the rising edge.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_Addr  input  16  CPU address bus.
- i_Read  input  1  read request, sampled with i_Addr.
- i_Write  input  1  write request, sampled with i_Addr and i_Data.
- i_Data  input  8  CPU write data.
- o_Data  output  8  read data, valid while o_Ack=1 for a read.
- o_Ack  output  1  one-cycle completion strobe for an accepted access.
- o_Busy  output  1  high while an access is in flight; new requests are ignored.
- o_Hit  output  1  combinational: i_Addr[15:8]==8'hFF and (i_Read|i_Write).
- o_IO_Req  output  1  IO request, held until ack or timeout.
- o_IO_Write  output  1  IO direction, 1 = write; stable while o_IO_Req=1.
- o_IO_Addr  output  7  IO offset (i_Addr[6:0]); stable while o_IO_Req=1.
- o_IO_Wdata  output  8  IO write data; stable while o_IO_Req=1.
- i_IO_Ack  input  1  peripheral completion, one cycle.
- i_IO_Rdata  input  8  peripheral read data, valid with i_IO_Ack.
- o_IE  output  8  current IE register contents, for the interrupt controller.

Behaviour:
- Reset (asynchronous, i_Reset_n=0) sets:
  - state IDLE;
  - o_Data=8'h00, o_Ack=0, o_Busy=0;
  - o_IO_Req=0, o_IO_Write=0, o_IO_Addr=0, o_IO_Wdata=0;
  - o_IE=8'h00, timeout counter 0.
- HRAM contents are NOT cleared by reset.
- Reset asserted mid-access aborts it: no o_Ack, o_IO_Req drops immediately, and no HRAM/IE write happens unless it was already committed on an earlier edge.
- Request acceptance:
  - Only in IDLE, and only when o_Hit=1.
  - i_Read and i_Write both high: treated as a write. The read is dropped with no separate ack.
  - Requests outside the high page are ignored and produce no ack.
- States:
  - IDLE: latch the address, direction and write data; select the target; go to LOCAL (HRAM/IE) or IO_WAIT (IO). o_Busy=1 from the following cycle.
  - LOCAL:
    - Write: commit on this edge. HRAM[addr[6:0]] for 0x80–0xFE, IE for 0xFF.
    - Read: o_Data = stored byte.
    - Pulse o_Ack for one cycle, then return to IDLE.
    - Total latency: request at cycle N -> o_Ack at cycle N+1.
    - A write is visible to a read accepted in the cycle after its o_Ack.
  - IO_WAIT:
    - o_IO_Req=1 with the latched address, direction and data held stable. The counter increments each cycle.
    - On i_IO_Ack: o_IO_Req drops; for a read, o_Data captures i_IO_Rdata; o_Ack pulses next cycle; go to IDLE.
    - If the counter reaches IO_TIMEOUT with no ack: o_IO_Req drops; o_Data=OPEN_BUS_VALUE for a read (a write is silently lost); o_Ack pulses; go to IDLE.
    - If i_IO_Ack arrives on the same cycle the timeout fires, the ack wins.
    - Minimum IO latency (ack in the first IO_WAIT cycle): request at N -> o_Ack at N+2.
    - The counter clears on entry to IO_WAIT.
- Address arithmetic:
  - The HRAM index is i_Addr[6:0]. Index 7'h7F is never HRAM; it decodes to IE.
  - No wrap-around: addresses below 0xFF00 never hit.
- o_Data holds its last value when o_Ack=0.
- i_IO_Ack seen outside IO_WAIT is ignored.

Test Plan:
- Reset release -> o_IE=8'h00, o_Ack=0, o_IO_Req=0. Write 0x1F to 0xFFFF -> o_Ack one cycle later, o_IE=8'h1F; read 0xFFFF -> o_Data=8'h1F.
- Write 0xA5 to 0xFF80 and 0x5A to 0xFFFE; read both back -> 8'hA5 and 8'h5A, each acked one cycle after the request; a request at 0xFE80 -> o_Hit=0, no ack.
- Read 0xFF44 with the peripheral acking after 3 cycles with 0x90 -> o_IO_Req=1 with o_IO_Addr=7'h44 for 3 cycles, then o_Ack with o_Data=8'h90.
- Read 0xFF10 with no peripheral ack (IO_TIMEOUT=8) -> o_IO_Req high for 8 cycles, then o_Ack with o_Data=8'hFF. Repeat with the ack arriving on the 8th cycle carrying 0x33 -> o_Data=8'h33.
- Assert i_Reset_n=0 while in IO_WAIT -> o_IO_Req=0 and o_Busy=0 immediately, no o_Ack; HRAM data written earlier still reads back correctly after reset release.
- Drive i_Read and i_Write together to 0xFF90 with data 0x77, then a new request while o_Busy=1 -> only the write is acked, the busy-time request is ignored, and a later read of 0xFF90 returns 8'h77.
